// File: rtl/systolic_feeder_if.sv
// systolic_feeder_if
// Bundles the controller-side and array-side signals of the systolic feeder.
//   master : the SRAM controller / stimulus side (drives starts, row stream)
//   slave  : the feeder itself (drives weight loads, skewed lanes, status)
// Signals:
//   start_weights, start_array, num_input  - control pulses and stream length
//   systolic_valid, systolic_data          - incoming row stream (N lanes of DW)
//   weight_load_en, weight_row_sel,
//   weight_row                             - one weight row per cycle to PE rows
//   array_in, array_in_valid               - diagonally skewed lanes, west edge
//   weights_done, inputs_done              - completion pulses
//   feeder_busy, protocol_err              - status
interface systolic_feeder_if #(
  parameter int N  = 8,
  parameter int DW = 8
) ();
  localparam int SW = (N > 1) ? $clog2(N) : 1;

  logic            start_weights;
  logic            start_array;
  logic [4:0]      num_input;
  logic            systolic_valid;
  logic [N*DW-1:0] systolic_data;
  logic            weight_load_en;
  logic [SW-1:0]   weight_row_sel;
  logic [N*DW-1:0] weight_row;
  logic [N*DW-1:0] array_in;
  logic [N-1:0]    array_in_valid;
  logic            weights_done;
  logic            inputs_done;
  logic            feeder_busy;
  logic            protocol_err;

  modport master (
    output start_weights, start_array, num_input, systolic_valid, systolic_data,
    input  weight_load_en, weight_row_sel, weight_row, array_in, array_in_valid,
           weights_done, inputs_done, feeder_busy, protocol_err
  );

  modport slave (
    input  start_weights, start_array, num_input, systolic_valid, systolic_data,
    output weight_load_en, weight_row_sel, weight_row, array_in, array_in_valid,
           weights_done, inputs_done, feeder_busy, protocol_err
  );
endinterface

// File: rtl/systolic_feeder.sv
// systolic_feeder
// Array-side receiver for the row stream from the SRAM controller.
//  - LOAD_W : captures N weight rows and presents them one per cycle to the
//             PE weight registers (weight_load_en / weight_row_sel / weight_row).
//  - STREAM : pushes input rows into per-lane delay lines so lane k reaches
//             the array k+1 cycles after its row was accepted.
//  - DRAIN  : lets the delay lines empty; inputs_done marks the last element
//             leaving lane N-1.
// Ports:
//   clk  - system clock
//   rst  - asynchronous active-high reset
//   bus  - systolic_feeder_if slave modport (all handshake/data signals)
module systolic_feeder #(
  parameter int N  = 8,
  parameter int DW = 8
) (
  input logic            clk,
  input logic            rst,
  systolic_feeder_if.slave bus
);
  localparam int SW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, LOAD_W, STREAM, DRAIN} state_t;

  state_t          state_reg, state_next;
  logic [SW-1:0]   wcount_reg, wcount_next;
  logic [SW-1:0]   dcount_reg, dcount_next;
  logic [4:0]      icount_reg, icount_next;
  logic [4:0]      num_reg, num_next;
  logic            loaded_reg, loaded_next;
  logic            wl_en_reg, wl_en_next;
  logic [SW-1:0]   sel_reg, sel_next;
  logic [N*DW-1:0] wrow_reg, wrow_next;
  logic            wdone_reg, wdone_next;
  logic            err_reg, err_next;
  logic            accept;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg  <= IDLE;
      wcount_reg <= '0;
      dcount_reg <= '0;
      icount_reg <= '0;
      num_reg    <= '0;
      loaded_reg <= 1'b0;
      wl_en_reg  <= 1'b0;
      sel_reg    <= '0;
      wrow_reg   <= '0;
      wdone_reg  <= 1'b0;
      err_reg    <= 1'b0;
    end else begin
      state_reg  <= state_next;
      wcount_reg <= wcount_next;
      dcount_reg <= dcount_next;
      icount_reg <= icount_next;
      num_reg    <= num_next;
      loaded_reg <= loaded_next;
      wl_en_reg  <= wl_en_next;
      sel_reg    <= sel_next;
      wrow_reg   <= wrow_next;
      wdone_reg  <= wdone_next;
      err_reg    <= err_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    wcount_next = wcount_reg;
    dcount_next = dcount_reg;
    icount_next = icount_reg;
    num_next    = num_reg;
    loaded_next = loaded_reg;
    wl_en_next  = 1'b0;
    sel_next    = '0;
    wrow_next   = '0;
    wdone_next  = 1'b0;
    err_next    = 1'b0;
    accept      = 1'b0;

    case (state_reg)
      IDLE: begin
        if (bus.start_weights) begin
          // A weight load always wins; a simultaneous start_array is flagged.
          state_next  = LOAD_W;
          loaded_next = 1'b0;
          wcount_next = '0;
          if (bus.start_array) err_next = 1'b1;
        end else if (bus.start_array) begin
          if (loaded_reg && (bus.num_input != 5'd0)) begin
            state_next  = STREAM;
            num_next    = bus.num_input;
            icount_next = '0;
          end else begin
            err_next = 1'b1;
          end
        end
        if (bus.systolic_valid) err_next = 1'b1;
      end

      LOAD_W: begin
        if (bus.start_weights || bus.start_array) err_next = 1'b1;
        if (bus.systolic_valid) begin
          wl_en_next = 1'b1;
          sel_next   = wcount_reg;
          wrow_next  = bus.systolic_data;
          if (wcount_reg == SW'(N - 1)) begin
            // The done pulse rides on the same registered cycle as the last load.
            wdone_next  = 1'b1;
            loaded_next = 1'b1;
            wcount_next = '0;
            state_next  = IDLE;
          end else begin
            wcount_next = wcount_reg + 1'b1;
          end
        end
      end

      STREAM: begin
        if (bus.start_weights || bus.start_array) err_next = 1'b1;
        if (bus.systolic_valid) begin
          if (icount_reg < num_reg) begin
            accept      = 1'b1;
            icount_next = icount_reg + 5'd1;
            if ((icount_reg + 5'd1) == num_reg) begin
              state_next  = DRAIN;
              dcount_next = '0;
            end
          end else begin
            err_next = 1'b1;
          end
        end
      end

      DRAIN: begin
        if (bus.start_weights || bus.start_array || bus.systolic_valid) err_next = 1'b1;
        // Row accepted at cycle t leaves lane N-1 at t+N, i.e. the N-th DRAIN cycle.
        if (dcount_reg == SW'(N - 1)) begin
          state_next  = IDLE;
          dcount_next = '0;
        end else begin
          dcount_next = dcount_reg + 1'b1;
        end
      end

      default: state_next = IDLE;
    endcase
  end

  // Per-lane delay lines: lane gi has gi+1 stages, so its output trails the
  // accepted row by gi+1 cycles. Non-accepted cycles enter as zero bubbles.
  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_lane
      logic [DW-1:0] dly_data  [0:gi];
      logic          dly_valid [0:gi];

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int j = 0; j <= gi; j++) begin
            dly_data[j]  <= '0;
            dly_valid[j] <= 1'b0;
          end
        end else begin
          dly_data[0]  <= accept ? bus.systolic_data[gi*DW +: DW] : '0;
          dly_valid[0] <= accept;
          for (int j = 1; j <= gi; j++) begin
            dly_data[j]  <= dly_data[j-1];
            dly_valid[j] <= dly_valid[j-1];
          end
        end
      end

      assign bus.array_in[gi*DW +: DW] = dly_data[gi];
      assign bus.array_in_valid[gi]    = dly_valid[gi];
    end
  endgenerate

  assign bus.weight_load_en = wl_en_reg;
  assign bus.weight_row_sel = sel_reg;
  assign bus.weight_row     = wrow_reg;
  assign bus.weights_done   = wdone_reg;
  assign bus.protocol_err   = err_reg;
  assign bus.feeder_busy    = (state_reg != IDLE);
  assign bus.inputs_done    = (state_reg == DRAIN) && (dcount_reg == SW'(N - 1));
endmodule

// File: tb/tb_systolic_feeder.sv
// tb_systolic_feeder
// Scoreboard bench: each driven row pushes its expected weight load or its
// expected per-lane outputs (with the cycle they must appear on); a negedge
// monitor pops and compares everything the DUT produces.
module tb_systolic_feeder;
  localparam int N  = 8;
  localparam int DW = 8;
  localparam int RW = N * DW;

  typedef struct packed {
    logic [DW-1:0] d;
    logic          last;
    logic [31:0]   at;
  } lane_item_t;

  typedef struct packed {
    logic [2:0]    sel;
    logic [RW-1:0] row;
    logic          last;
    logic [31:0]   at;
  } w_item_t;

  logic        clk;
  logic        rst;
  int          checks = 0;
  int          errors = 0;
  logic [31:0] cyc    = 0;
  bit          mon_en = 0;

  lane_item_t  lane_q [N][$];
  w_item_t     w_q[$];
  logic [31:0] err_q[$];

  systolic_feeder_if #(.N(N), .DW(DW)) bus ();

  systolic_feeder #(.N(N), .DW(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [RW-1:0] obs, input logic [RW-1:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.start_weights  = 1'b0;
    bus.start_array    = 1'b0;
    bus.num_input      = 5'd0;
    bus.systolic_valid = 1'b0;
    bus.systolic_data  = '0;
  endtask

  // Present one cycle of inputs, then return to idle inputs.
  task automatic drive(input logic sw, input logic sa, input logic [4:0] ni,
                       input logic v, input logic [RW-1:0] d);
    bus.start_weights  = sw;
    bus.start_array    = sa;
    bus.num_input      = ni;
    bus.systolic_valid = v;
    bus.systolic_data  = d;
    step();
    idle_inputs();
  endtask

  task automatic expect_err();
    err_q.push_back(cyc + 1);
  endtask

  task automatic push_weight(input int idx, input logic [RW-1:0] row, input logic last);
    w_item_t it;
    it.sel  = 3'(idx);
    it.row  = row;
    it.last = last;
    it.at   = cyc + 1;
    w_q.push_back(it);
  endtask

  task automatic push_input(input logic [RW-1:0] row, input logic last);
    lane_item_t it;
    for (int k = 0; k < N; k++) begin
      it.d    = row[k*DW +: DW];
      it.last = last;
      it.at   = cyc + 32'(k) + 1;
      lane_q[k].push_back(it);
    end
  endtask

  function automatic int lanes_pending();
    int s = 0;
    for (int k = 0; k < N; k++) s += lane_q[k].size();
    return s;
  endfunction

  task automatic wait_drain(input string tag);
    int n = 0;
    while (lanes_pending() != 0 && n < 64) begin
      step();
      n++;
    end
    chk(tag, 64'(lanes_pending()), 64'd0);
  endtask

  task automatic flush_scoreboard();
    for (int k = 0; k < N; k++) lane_q[k].delete();
    w_q.delete();
    err_q.delete();
  endtask

  always @(negedge clk) begin : monitor
    lane_item_t li;
    w_item_t    wi;
    logic       exp_done;
    logic       exp_err;
    if (mon_en) begin
      if (bus.weight_load_en) begin
        if (w_q.size() != 0) begin
          wi = w_q.pop_front();
          chk("w_sel", 64'(bus.weight_row_sel), 64'(wi.sel));
          chk("w_row", bus.weight_row, wi.row);
          chk("w_cycle", 64'(cyc), 64'(wi.at));
          chk("weights_done", 64'(bus.weights_done), 64'(wi.last));
          $display("weight load cyc=%0d sel=%0d row=%h done=%0b",
                   cyc, bus.weight_row_sel, bus.weight_row, bus.weights_done);
        end else begin
          chk("w_unexpected", 64'd1, 64'd0);
        end
      end else begin
        chk("weights_done_idle", 64'(bus.weights_done), 64'd0);
      end

      exp_done = 1'b0;
      for (int k = 0; k < N; k++) begin
        if (bus.array_in_valid[k]) begin
          if (lane_q[k].size() != 0) begin
            li = lane_q[k].pop_front();
            chk($sformatf("lane%0d_data", k), 64'(bus.array_in[k*DW +: DW]), 64'(li.d));
            chk($sformatf("lane%0d_cycle", k), 64'(cyc), 64'(li.at));
            if (k == N - 1) exp_done = li.last;
          end else begin
            chk($sformatf("lane%0d_unexpected", k), 64'd1, 64'd0);
          end
        end else begin
          chk($sformatf("lane%0d_bubble", k), 64'(bus.array_in[k*DW +: DW]), 64'd0);
        end
      end
      chk("inputs_done", 64'(bus.inputs_done), 64'(exp_done));
      if (bus.inputs_done) $display("inputs_done cyc=%0d", cyc);

      exp_err = (err_q.size() != 0) && (err_q[0] == cyc);
      if (exp_err) void'(err_q.pop_front());
      chk("protocol_err", 64'(bus.protocol_err), 64'(exp_err));
    end
  end

  logic [RW-1:0] row;

  initial begin
    rst = 1'b1;
    idle_inputs();
    repeat (2) step();

    // Reset state.
    chk("rst_wl_en", 64'(bus.weight_load_en), 64'd0);
    chk("rst_sel", 64'(bus.weight_row_sel), 64'd0);
    chk("rst_wrow", bus.weight_row, '0);
    chk("rst_array_in", bus.array_in, '0);
    chk("rst_valid", 64'(bus.array_in_valid), 64'd0);
    chk("rst_wdone", 64'(bus.weights_done), 64'd0);
    chk("rst_idone", 64'(bus.inputs_done), 64'd0);
    chk("rst_busy", 64'(bus.feeder_busy), 64'd0);
    chk("rst_err", 64'(bus.protocol_err), 64'd0);
    rst = 1'b0;
    mon_en = 1'b1;
    step();

    // start_array before any weights: error, stay idle.
    expect_err();
    drive(1'b0, 1'b1, 5'd8, 1'b0, '0);
    chk("noweights_busy", 64'(bus.feeder_busy), 64'd0);
    repeat (2) step();

    // Weight load: 8 back-to-back rows.
    drive(1'b1, 1'b0, 5'd0, 1'b0, '0);
    chk("loadw_busy", 64'(bus.feeder_busy), 64'd1);
    for (int i = 0; i < N; i++) begin
      row = {N{8'(i + 1)}};
      push_weight(i, row, i == N - 1);
      drive(1'b0, 1'b0, 5'd0, 1'b1, row);
    end
    chk("loadw_done_busy", 64'(bus.feeder_busy), 64'd0);
    step();
    chk("wq_after_load", 64'(w_q.size()), 64'd0);

    // num_input = 0 is rejected even with weights loaded.
    expect_err();
    drive(1'b0, 1'b1, 5'd0, 1'b0, '0);
    chk("num0_busy", 64'(bus.feeder_busy), 64'd0);

    // Full stream of 8 rows, one per cycle.
    drive(1'b0, 1'b1, 5'd8, 1'b0, '0);
    chk("stream_busy", 64'(bus.feeder_busy), 64'd1);
    for (int i = 1; i <= N; i++) begin
      row = {N{8'(i * 17)}};
      push_input(row, i == N);
      drive(1'b0, 1'b0, 5'd0, 1'b1, row);
    end
    wait_drain("stream8_drained");
    chk("stream8_idle", 64'(bus.feeder_busy), 64'd0);

    // Stream of 5 with a 2-cycle gap after row 2, plus one extra row in DRAIN.
    drive(1'b0, 1'b1, 5'd5, 1'b0, '0);
    for (int i = 0; i < 5; i++) begin
      if (i == 3) repeat (2) step();
      row = {N{8'(8'hA0 + i)}};
      push_input(row, i == 4);
      drive(1'b0, 1'b0, 5'd0, 1'b1, row);
    end
    expect_err();
    drive(1'b0, 1'b0, 5'd0, 1'b1, {N{8'hEE}});
    wait_drain("stream5_drained");
    chk("stream5_idle", 64'(bus.feeder_busy), 64'd0);

    // Reset in the middle of a stream.
    drive(1'b0, 1'b1, 5'd8, 1'b0, '0);
    for (int i = 0; i < 3; i++) begin
      row = {N{8'(8'h30 + i)}};
      push_input(row, 1'b0);
      drive(1'b0, 1'b0, 5'd0, 1'b1, row);
    end
    #1;
    rst = 1'b1;
    flush_scoreboard();
    #1;
    chk("arst_array_in", bus.array_in, '0);
    chk("arst_valid", 64'(bus.array_in_valid), 64'd0);
    chk("arst_busy", 64'(bus.feeder_busy), 64'd0);
    chk("arst_idone", 64'(bus.inputs_done), 64'd0);
    chk("arst_err", 64'(bus.protocol_err), 64'd0);
    step();
    rst = 1'b0;
    step();
    expect_err();
    drive(1'b0, 1'b1, 5'd4, 1'b0, '0);
    chk("postrst_busy", 64'(bus.feeder_busy), 64'd0);
    step();

    // Simultaneous starts: weights win, error flagged.
    expect_err();
    drive(1'b1, 1'b1, 5'd3, 1'b0, '0);
    chk("both_busy", 64'(bus.feeder_busy), 64'd1);
    for (int i = 0; i < N; i++) begin
      row = {N{8'(8'h50 + i)}};
      push_weight(i, row, i == N - 1);
      if (i == 3) begin
        expect_err();
        drive(1'b0, 1'b1, 5'd2, 1'b1, row);
      end else begin
        drive(1'b0, 1'b0, 5'd0, 1'b1, row);
      end
    end
    expect_err();
    drive(1'b0, 1'b0, 5'd0, 1'b1, {N{8'h99}});
    chk("ninth_busy", 64'(bus.feeder_busy), 64'd0);

    // Minimum stream length after reload.
    drive(1'b0, 1'b1, 5'd1, 1'b0, '0);
    row = 64'h0123_4567_89AB_CDEF;
    push_input(row, 1'b1);
    drive(1'b0, 1'b0, 5'd0, 1'b1, row);
    wait_drain("stream1_drained");

    repeat (3) step();
    chk("wq_empty", 64'(w_q.size()), 64'd0);
    chk("errq_empty", 64'(err_q.size()), 64'd0);
    mon_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end
endmodule
